// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multicycle RISC-V control unit: state codes,
// opcode constants, ALU operation codes (also used by the ALU) and the
// decoded-field bundle passed from the decoder to the FSM.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'b0000,
    ST_FETCH   = 4'b0001,
    ST_DECODE  = 4'b0010,
    ST_REGREAD = 4'b0011,
    ST_EXEC    = 4'b0101,
    ST_EXEC_BR = 4'b0110,
    ST_MEM     = 4'b0111,
    ST_WB      = 4'b1000,
    ST_PCUPD   = 4'b1001,
    ST_HALT    = 4'b1111
  } state_t;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ADDI   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_ADDI = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;

  // Instruction class steers the FSM after REGREAD; illegal decodes are NONE.
  typedef enum logic [2:0] {
    CLS_NONE   = 3'd0,
    CLS_ALU    = 3'd1,
    CLS_LOAD   = 3'd2,
    CLS_STORE  = 3'd3,
    CLS_BRANCH = 3'd4
  } iclass_t;

  typedef struct packed {
    logic [3:0]  alucontrol;
    logic        alusrc;
    logic        branch;
    logic [11:0] immediate;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    iclass_t     iclass;
    logic        illegal;
  } dec_t;

  // EXEC_BR lasts this many cycles: the ALU zero flag lags its result by one.
  localparam logic [1:0] BR_HOLD_CYCLES = 2'd2;

  function automatic logic is_mem_access(input iclass_t c);
    return (c == CLS_LOAD) || (c == CLS_STORE);
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control-unit <-> datapath bundle. The master side is the control unit; the
// slave side is the datapath/memory that supplies the instruction and ready.
// The sticky `illegal` flag exists only when ILLEGAL_TRAP_EN is defined.
interface multicycle_control_if;
  logic [31:0] instruction;
  logic        mem_ready;
  logic [3:0]  estado;
  logic [3:0]  alucontrol;
  logic        alusrc;
  logic        branch;
  logic [11:0] immediate;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic        irwrite;
  logic        regwrite;
  logic        memread;
  logic        memwrite;
  logic        memtoreg;
  logic        pcwrite;
`ifdef ILLEGAL_TRAP_EN
  logic        illegal;

  modport master (
    input  instruction, mem_ready,
    output estado, alucontrol, alusrc, branch, immediate, rs1, rs2, rd,
           irwrite, regwrite, memread, memwrite, memtoreg, pcwrite, illegal
  );
  modport slave (
    output instruction, mem_ready,
    input  estado, alucontrol, alusrc, branch, immediate, rs1, rs2, rd,
           irwrite, regwrite, memread, memwrite, memtoreg, pcwrite, illegal
  );
`else
  modport master (
    input  instruction, mem_ready,
    output estado, alucontrol, alusrc, branch, immediate, rs1, rs2, rd,
           irwrite, regwrite, memread, memwrite, memtoreg, pcwrite
  );
  modport slave (
    output instruction, mem_ready,
    input  estado, alucontrol, alusrc, branch, immediate, rs1, rs2, rd,
           irwrite, regwrite, memread, memwrite, memtoreg, pcwrite
  );
`endif
endinterface

// File: rtl/multicycle_control_instr_decoder.sv
// Combinational instruction decoder: maps a 32-bit instruction word to the
// control fields and instruction class. Illegal encodings clear alucontrol,
// alusrc, branch and immediate and report illegal=1.
module instr_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  // Decode opcode/funct fields into ALU op, operand select and immediate.
  always_comb begin
    dec            = '0;
    dec.rs1        = instr[19:15];
    dec.rs2        = instr[24:20];
    dec.rd         = instr[11:7];
    dec.iclass     = CLS_NONE;
    dec.illegal    = 1'b0;
    unique case (opcode)
      OP_RTYPE: begin
        dec.iclass = CLS_ALU;
        unique case (funct3)
          3'b111: dec.alucontrol = ALU_AND;
          3'b110: dec.alucontrol = ALU_OR;
          3'b100: dec.alucontrol = ALU_XOR;
          3'b101: dec.alucontrol = ALU_SRL;
          3'b000: begin
            if (funct7 == 7'b0000000)      dec.alucontrol = ALU_ADD;
            else if (funct7 == 7'b0100000) dec.alucontrol = ALU_SUB;
            else                           dec.illegal    = 1'b1;
          end
          default: dec.illegal = 1'b1;
        endcase
      end
      OP_ADDI: begin
        if (funct3 == 3'b000) begin
          dec.iclass     = CLS_ALU;
          dec.alucontrol = ALU_ADDI;
          dec.alusrc     = 1'b1;
          dec.immediate  = instr[31:20];
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OP_LOAD: begin
        dec.iclass     = CLS_LOAD;
        dec.alucontrol = ALU_ADD;
        dec.alusrc     = 1'b1;
        dec.immediate  = instr[31:20];
      end
      OP_STORE: begin
        dec.iclass     = CLS_STORE;
        dec.alucontrol = ALU_ADD;
        dec.alusrc     = 1'b1;
        dec.immediate  = {instr[31:25], instr[11:7]};
      end
      OP_BRANCH: begin
        if (funct3 == 3'b000) begin
          dec.iclass     = CLS_BRANCH;
          dec.alucontrol = ALU_SUB;
          dec.alusrc     = 1'b1;
          dec.branch     = 1'b1;
          dec.immediate  = {instr[31], instr[7], instr[30:25], instr[11:8]};
        end else begin
          dec.illegal = 1'b1;
        end
      end
      default: dec.illegal = 1'b1;
    endcase
    if (dec.illegal) begin
      dec.alucontrol = 4'b0000;
      dec.alusrc     = 1'b0;
      dec.branch     = 1'b0;
      dec.immediate  = 12'h000;
      dec.iclass     = CLS_NONE;
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle control unit for the RISC-V datapath. Sequences each
// instruction through fetch/decode/regread/exec/mem/writeback/pc-update and
// drives registered control fields and single-state strobes.
// Optional feature macro: ILLEGAL_TRAP_EN (illegal opcode traps to HALT and
// raises a sticky `illegal` flag; otherwise it executes as a NOP).
//
//   state      | meaning
//   -----------+----------------------------------------------------------
//   IDLE  0000 | after reset, moves straight to FETCH
//   FETCH 0001 | wait for mem_ready; instruction and its decode captured
//   DECODE 0010| fields valid; illegal -> PCUPD (HALT with trap enabled)
//   REGREAD 0011| register file read; beq -> EXEC_BR, else EXEC
//   EXEC  0101 | ALU op; lw/sw -> MEM, R-type/addi -> WB
//   EXEC_BR 0110| beq compare, held 2 cycles for the registered zero flag
//   MEM   0111 | data access, wait for mem_ready; lw -> WB, sw -> PCUPD
//   WB    1000 | register writeback
//   PCUPD 1001 | PC update, back to FETCH
//   HALT  1111 | illegal-opcode trap, held until reset
module multicycle_control
  import riscv_ctrl_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  multicycle_control_if.master    bus
);

  state_t     state_q, state_d;
  dec_t       dec_w;
  dec_t       fld_q, fld_d;
  logic [1:0] br_cnt_q, br_cnt_d;
  logic       fetch_done;

  logic irwrite_q, irwrite_d;
  logic regwrite_q, regwrite_d;
  logic memread_q, memread_d;
  logic memwrite_q, memwrite_d;
  logic memtoreg_q, memtoreg_d;
  logic pcwrite_q, pcwrite_d;
`ifdef ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;
`endif

  instr_decoder u_dec (
    .instr (bus.instruction),
    .dec   (dec_w)
  );

  assign fetch_done = (state_q == ST_FETCH) && bus.mem_ready;

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; mem_ready is only looked at in FETCH and MEM.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    state_d = ST_FETCH;
      ST_FETCH:   if (bus.mem_ready) state_d = ST_DECODE;
      ST_DECODE: begin
        if (fld_q.illegal) begin
`ifdef ILLEGAL_TRAP_EN
          state_d = ST_HALT;
`else
          state_d = ST_PCUPD;
`endif
        end else begin
          state_d = ST_REGREAD;
        end
      end
      ST_REGREAD: state_d = (fld_q.iclass == CLS_BRANCH) ? ST_EXEC_BR : ST_EXEC;
      ST_EXEC_BR: if (br_cnt_q == 2'd0) state_d = ST_PCUPD;
      ST_EXEC:    state_d = is_mem_access(fld_q.iclass) ? ST_MEM : ST_WB;
      ST_MEM: begin
        if (bus.mem_ready)
          state_d = (fld_q.iclass == CLS_LOAD) ? ST_WB : ST_PCUPD;
      end
      ST_WB:      state_d = ST_PCUPD;
      ST_PCUPD:   state_d = ST_FETCH;
`ifdef ILLEGAL_TRAP_EN
      ST_HALT:    state_d = ST_HALT;
`endif
      default:    state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs, derived from the state being
  // entered so each strobe lines up exactly with its state code. Fields are
  // captured on the fetch-complete edge so they are already valid in DECODE.
  always_comb begin
    fld_d      = fetch_done ? dec_w : fld_q;
    br_cnt_d   = br_cnt_q;
    if (state_d == ST_EXEC_BR) begin
      if (state_q != ST_EXEC_BR) br_cnt_d = BR_HOLD_CYCLES - 2'd1;
      else if (br_cnt_q != 2'd0) br_cnt_d = br_cnt_q - 2'd1;
    end
    irwrite_d  = fetch_done;
    memread_d  = (state_d == ST_MEM) && (fld_q.iclass == CLS_LOAD);
    memwrite_d = (state_d == ST_MEM) && (fld_q.iclass == CLS_STORE);
    regwrite_d = (state_d == ST_WB);
    memtoreg_d = (state_d == ST_WB) && (fld_q.iclass == CLS_LOAD);
    pcwrite_d  = (state_d == ST_PCUPD);
`ifdef ILLEGAL_TRAP_EN
    illegal_d  = illegal_q || (state_d == ST_HALT);
`endif
  end

  // Output and field registers; reset abandons any pending access.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fld_q      <= '0;
      br_cnt_q   <= 2'd0;
      irwrite_q  <= 1'b0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      pcwrite_q  <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
      illegal_q  <= 1'b0;
`endif
    end else begin
      fld_q      <= fld_d;
      br_cnt_q   <= br_cnt_d;
      irwrite_q  <= irwrite_d;
      regwrite_q <= regwrite_d;
      memread_q  <= memread_d;
      memwrite_q <= memwrite_d;
      memtoreg_q <= memtoreg_d;
      pcwrite_q  <= pcwrite_d;
`ifdef ILLEGAL_TRAP_EN
      illegal_q  <= illegal_d;
`endif
    end
  end

  assign bus.estado     = state_q;
  assign bus.alucontrol = fld_q.alucontrol;
  assign bus.alusrc     = fld_q.alusrc;
  assign bus.branch     = fld_q.branch;
  assign bus.immediate  = fld_q.immediate;
  assign bus.rs1        = fld_q.rs1;
  assign bus.rs2        = fld_q.rs2;
  assign bus.rd         = fld_q.rd;
  assign bus.irwrite    = irwrite_q;
  assign bus.regwrite   = regwrite_q;
  assign bus.memread    = memread_q;
  assign bus.memwrite   = memwrite_q;
  assign bus.memtoreg   = memtoreg_q;
  assign bus.pcwrite    = pcwrite_q;
`ifdef ILLEGAL_TRAP_EN
  assign bus.illegal    = illegal_q;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle expected state/strobe
// records are queued when an instruction is applied and popped each cycle.
module tb_multicycle_control;
  import riscv_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  multicycle_control_if bus ();

  multicycle_control dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [3:0] st;
    logic [4:0] stb;   // {regwrite, memread, memwrite, memtoreg, pcwrite}
  } exp_t;

  localparam logic [4:0] NO = 5'b00000;
  localparam logic [4:0] RW = 5'b10000;
  localparam logic [4:0] MR = 5'b01000;
  localparam logic [4:0] MW = 5'b00100;
  localparam logic [4:0] MT = 5'b00010;
  localparam logic [4:0] PW = 5'b00001;

  localparam int K_ALU = 0;
  localparam int K_LW  = 1;
  localparam int K_SW  = 2;
  localparam int K_BEQ = 3;
  localparam int K_ILL = 4;

  exp_t       q[$];
  int         checks = 0;
  int         errors = 0;
  logic [3:0] cur_st;
  int         fetch_wait_g = 0, mem_wait_g = 0, fcnt = 0, mcnt = 0;
  string      name = "reset";

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s/%s observed=%0h expected=%0h", name, tag, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] st, input logic [4:0] stb);
    exp_t e;
    e.st  = st;
    e.stb = stb;
    q.push_back(e);
  endtask

  // One clock: drive mem_ready from the expected current state, then compare.
  task automatic step();
    exp_t e;
    if (cur_st == ST_FETCH) begin
      bus.mem_ready = (fcnt >= fetch_wait_g);
      if (fcnt < fetch_wait_g) fcnt++;
    end else if (cur_st == ST_MEM) begin
      bus.mem_ready = (mcnt >= mem_wait_g);
      if (mcnt < mem_wait_g) mcnt++;
    end else begin
      bus.mem_ready = 1'($urandom_range(0, 1));
    end
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("estado", {28'd0, bus.estado}, {28'd0, e.st});
    chk("strobes", {27'd0, bus.regwrite, bus.memread, bus.memwrite, bus.memtoreg, bus.pcwrite},
        {27'd0, e.stb});
    cur_st = e.st;
  endtask

  task automatic drain();
    while (q.size() > 0) step();
  endtask

  // Expected per-cycle trace of one instruction, starting from FETCH.
  task automatic expect_instr(input int kind, input int fw, input int mw);
    fetch_wait_g = fw;
    mem_wait_g   = mw;
    fcnt         = 0;
    mcnt         = 0;
    repeat (fw) push(ST_FETCH, NO);
    push(ST_DECODE, NO);
    if (kind == K_ILL) begin
`ifdef ILLEGAL_TRAP_EN
      repeat (5) push(ST_HALT, NO);
`else
      push(ST_PCUPD, PW);
      push(ST_FETCH, NO);
`endif
    end else begin
      push(ST_REGREAD, NO);
      case (kind)
        K_LW: begin
          push(ST_EXEC, NO);
          repeat (mw + 1) push(ST_MEM, MR);
          push(ST_WB, RW | MT);
        end
        K_SW: begin
          push(ST_EXEC, NO);
          repeat (mw + 1) push(ST_MEM, MW);
        end
        K_BEQ: begin
          push(ST_EXEC_BR, NO);
          push(ST_EXEC_BR, NO);
        end
        default: begin
          push(ST_EXEC, NO);
          push(ST_WB, RW);
        end
      endcase
      push(ST_PCUPD, PW);
      push(ST_FETCH, NO);
    end
  endtask

  task automatic chk_fields(input logic [3:0] alu, input logic asrc, input logic br,
                            input logic chk_imm, input logic [11:0] imm,
                            input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rdv);
    chk("alucontrol", {28'd0, bus.alucontrol}, {28'd0, alu});
    chk("alusrc", {31'd0, bus.alusrc}, {31'd0, asrc});
    chk("branch", {31'd0, bus.branch}, {31'd0, br});
    if (chk_imm) chk("immediate", {20'd0, bus.immediate}, {20'd0, imm});
    chk("rs1", {27'd0, bus.rs1}, {27'd0, r1});
    chk("rs2", {27'd0, bus.rs2}, {27'd0, r2});
    chk("rd", {27'd0, bus.rd}, {27'd0, rdv});
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.instruction = 32'h0;
    bus.mem_ready   = 1'b0;
    cur_st          = ST_IDLE;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_estado", {28'd0, bus.estado}, 32'd0);
    chk("rst_strobes", {26'd0, bus.irwrite, bus.regwrite, bus.memread, bus.memwrite,
                        bus.memtoreg, bus.pcwrite}, 32'd0);
    chk_fields(4'b0000, 1'b0, 1'b0, 1'b1, 12'h000, 5'd0, 5'd0, 5'd0);
`ifdef ILLEGAL_TRAP_EN
    chk("rst_illegal", {31'd0, bus.illegal}, 32'd0);
`endif

    rst_n = 1'b1;
    push(ST_FETCH, NO);
    drain();

    name = "add";
    bus.instruction = 32'h002081B3;
    expect_instr(K_ALU, 0, 0);
    drain();
    chk_fields(ALU_ADD, 1'b0, 1'b0, 1'b0, 12'h000, 5'd1, 5'd2, 5'd3);

    name = "sub_fetchwait";
    bus.instruction = 32'h402081B3;
    expect_instr(K_ALU, 2, 0);
    drain();
    chk_fields(ALU_SUB, 1'b0, 1'b0, 1'b0, 12'h000, 5'd1, 5'd2, 5'd3);

    name = "addi";
    bus.instruction = 32'h00500093;
    expect_instr(K_ALU, 0, 0);
    drain();
    chk_fields(ALU_ADDI, 1'b1, 1'b0, 1'b1, 12'h005, 5'd0, 5'd5, 5'd1);

    name = "lw_wait3";
    bus.instruction = 32'h0080A103;
    expect_instr(K_LW, 0, 3);
    drain();
    chk_fields(ALU_ADD, 1'b1, 1'b0, 1'b1, 12'h008, 5'd1, 5'd8, 5'd2);

    name = "sw";
    bus.instruction = 32'h0020A223;
    expect_instr(K_SW, 0, 0);
    drain();
    chk_fields(ALU_ADD, 1'b1, 1'b0, 1'b1, 12'h004, 5'd1, 5'd2, 5'd4);

    name = "beq";
    bus.instruction = 32'h00208463;
    expect_instr(K_BEQ, 0, 0);
    drain();
    chk_fields(ALU_SUB, 1'b1, 1'b1, 1'b1, 12'h004, 5'd1, 5'd2, 5'd8);

    name = "lw_nowait";
    bus.instruction = 32'h0080A103;
    expect_instr(K_LW, 1, 0);
    drain();

    name = "rst_in_exec";
    bus.instruction = 32'h002081B3;
    fetch_wait_g = 0; fcnt = 0;
    push(ST_DECODE, NO); push(ST_REGREAD, NO); push(ST_EXEC, NO);
    drain();
    rst_n = 1'b0;
    push(ST_IDLE, NO); push(ST_IDLE, NO);
    drain();
    chk_fields(4'b0000, 1'b0, 1'b0, 1'b1, 12'h000, 5'd0, 5'd0, 5'd0);
    rst_n = 1'b1;
    push(ST_FETCH, NO);
    drain();
    name = "add_after_rst";
    expect_instr(K_ALU, 0, 0);
    drain();
    chk_fields(ALU_ADD, 1'b0, 1'b0, 1'b0, 12'h000, 5'd1, 5'd2, 5'd3);

    name = "rst_in_mem";
    bus.instruction = 32'h0080A103;
    fetch_wait_g = 0; fcnt = 0; mem_wait_g = 1000; mcnt = 0;
    push(ST_DECODE, NO); push(ST_REGREAD, NO); push(ST_EXEC, NO);
    push(ST_MEM, MR); push(ST_MEM, MR);
    drain();
    rst_n = 1'b0;
    push(ST_IDLE, NO);
    drain();
    rst_n = 1'b1;
    push(ST_FETCH, NO);
    drain();

    name = "illegal";
    bus.instruction = 32'hFFFFFFFF;
    expect_instr(K_ILL, 0, 0);
    drain();
    chk_fields(4'b0000, 1'b0, 1'b0, 1'b1, 12'h000, 5'd31, 5'd31, 5'd31);
`ifdef ILLEGAL_TRAP_EN
    chk("illegal_flag", {31'd0, bus.illegal}, 32'd1);
    rst_n = 1'b0;
    push(ST_IDLE, NO);
    drain();
    chk("illegal_clr", {31'd0, bus.illegal}, 32'd0);
    rst_n = 1'b1;
    push(ST_FETCH, NO);
    drain();
`endif

    name = "addi_final";
    bus.instruction = 32'h00500093;
    expect_instr(K_ALU, 0, 0);
    drain();
    chk_fields(ALU_ADDI, 1'b1, 1'b0, 1'b1, 12'h005, 5'd0, 5'd5, 5'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
